// File: rtl/multiplier_pkg.sv
// Shared definitions for the shift-add multiplier.
// Holds the sign-handling helper macros, the default operand width, the FSM state enum,
// the product type and the iteration counter width helper.

`ifndef LOGIC
`define LOGIC(w) logic [(w)-1:0]
`endif
`ifndef MSB
`define MSB(x) x[$bits(x)-1]
`endif
`ifndef ZERO
`define ZERO(w) {(w){1'b0}}
`endif

package multiplier_pkg;

    localparam int unsigned DefaultWidth = 32;

    // Counter must be able to hold the iteration count itself, hence +1.
    localparam int unsigned CntWidth = $clog2(DefaultWidth + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    typedef logic [2*DefaultWidth-1:0] product_t;

    function automatic int unsigned cnt_width(int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/multiplier_if.sv
// Handshake and operand/result bundle between the execute stage and the multiplier.
// master: start, is_unsigned, multiplicand, multiplier out; busy, done, hi, lo in.
// slave : the mirror image, used by the multiplier itself.

interface multiplier_if
    import multiplier_pkg::*;
#(
    parameter int unsigned BitWidth = DefaultWidth
) ();

    logic                start;
    logic                is_unsigned;
    logic [BitWidth-1:0] multiplicand;
    logic [BitWidth-1:0] multiplier;
    logic                busy;
    logic                done;
    logic [BitWidth-1:0] hi;
    logic [BitWidth-1:0] lo;

    modport master (
        output start,
        output is_unsigned,
        output multiplicand,
        output multiplier,
        input  busy,
        input  done,
        input  hi,
        input  lo
    );

    modport slave (
        input  start,
        input  is_unsigned,
        input  multiplicand,
        input  multiplier,
        output busy,
        output done,
        output hi,
        output lo
    );

endinterface

// File: rtl/multiplier_cond_negate.sv
// Conditional two's-complement negation.
// Ports: data_i (Width) value, neg_i negate when high, data_o (Width) result.

module multiplier_cond_negate #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] data_i,
    input  logic             neg_i,
    output logic [Width-1:0] data_o
);

    assign data_o = neg_i ? (`ZERO(Width) - data_i) : data_i;

endmodule

// File: rtl/multiplier.sv
// Multi-cycle radix-2 shift-add multiplier for MULT/MULTU.
// Operands are reduced to magnitudes on start, multiplied unsigned over BitWidth cycles,
// and the sign is reapplied to the full product on the last iteration.
// Ports: clk clock; reset synchronous active-high; bus slave side of multiplier_if
// (start/is_unsigned/multiplicand/multiplier in, busy/done/hi/lo out).

module multiplier
    import multiplier_pkg::*;
#(
    parameter int unsigned BitWidth = DefaultWidth
) (
    input  logic           clk,
    input  logic           reset,
    multiplier_if.slave    bus
);

    localparam int unsigned CntW     = cnt_width(BitWidth);
    localparam int unsigned ProdW    = 2 * BitWidth;
    localparam logic [CntW-1:0] LastIter = CntW'(BitWidth - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            neg_q, neg_d;
    `LOGIC(BitWidth) mcand_q, mcand_d;
    `LOGIC(BitWidth) upper_q, upper_d;
    `LOGIC(BitWidth) lower_q, lower_d;
    `LOGIC(BitWidth) hi_q, hi_d;
    `LOGIC(BitWidth) lo_q, lo_d;

    // Operand magnitudes; -2^(BitWidth-1) maps onto itself, which is correct unsigned.
    logic            neg_a, neg_b;
    `LOGIC(BitWidth) mag_a, mag_b;

    assign neg_a = ~bus.is_unsigned & `MSB(bus.multiplicand);
    assign neg_b = ~bus.is_unsigned & `MSB(bus.multiplier);

    multiplier_cond_negate #(
        .Width (BitWidth)
    ) u_neg_a (
        .data_i (bus.multiplicand),
        .neg_i  (neg_a),
        .data_o (mag_a)
    );

    multiplier_cond_negate #(
        .Width (BitWidth)
    ) u_neg_b (
        .data_i (bus.multiplier),
        .neg_i  (neg_b),
        .data_o (mag_b)
    );

    // One iteration: conditional add into the upper half keeping the carry, then the
    // {carry, upper, lower} shift right is just a re-slice.
    `LOGIC(BitWidth+1) sum;
    `LOGIC(ProdW)      step_prod;
    `LOGIC(ProdW)      signed_prod;

    assign sum       = lower_q[0] ? ({1'b0, upper_q} + {1'b0, mcand_q}) : {1'b0, upper_q};
    assign step_prod = {sum, lower_q[BitWidth-1:1]};

    multiplier_cond_negate #(
        .Width (ProdW)
    ) u_neg_prod (
        .data_i (step_prod),
        .neg_i  (neg_q),
        .data_o (signed_prod)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        mcand_d = mcand_q;
        upper_d = upper_q;
        lower_d = lower_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    mcand_d = mag_a;
                    lower_d = mag_b;
                    upper_d = `ZERO(BitWidth);
                    neg_d   = ~bus.is_unsigned &
                              (`MSB(bus.multiplicand) ^ `MSB(bus.multiplier));
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                upper_d = step_prod[ProdW-1:BitWidth];
                lower_d = step_prod[BitWidth-1:0];
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastIter) begin
                    hi_d    = signed_prod[ProdW-1:BitWidth];
                    lo_d    = signed_prod[BitWidth-1:0];
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            mcand_q <= '0;
            upper_q <= '0;
            lower_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            mcand_q <= mcand_d;
            upper_q <= upper_d;
            lower_q <= lower_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = (state_q != StIdle);
    assign bus.done = (state_q == StDone);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for the shift-add multiplier: directed corner cases plus random
// operands, compared against a plain-arithmetic product model.

module tb_multiplier;

    localparam int unsigned W = 32;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    multiplier_if #(.BitWidth(W)) bus ();

    multiplier #(
        .BitWidth (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ref_mul(logic [31:0] a, logic [31:0] b, logic u);
        longint sa;
        longint sb;
        if (u) return {32'h0, a} * {32'h0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check latency, busy window, result, done width, and hold.
    task automatic run_op(string tag, logic [31:0] a, logic [31:0] b, logic u);
        logic [63:0] exp;
        int          n;
        int          busy_cnt;
        exp              = ref_mul(a, b, u);
        bus.start        = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.is_unsigned  = u;
        tick();
        bus.start        = 1'b0;
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
        bus.is_unsigned  = 1'($urandom);
        chk({tag, ".busy_start"}, 64'(bus.busy), 64'd1);
        n        = 0;
        busy_cnt = 1;
        while (bus.done !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (bus.busy === 1'b1) busy_cnt++;
        end
        chk({tag, ".latency"}, 64'(n), 64'd32);
        chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd33);
        chk({tag, ".hilo"}, {bus.hi, bus.lo}, exp);
        tick();
        chk({tag, ".done_fall"}, {62'd0, bus.done, bus.busy}, 64'd0);
        chk({tag, ".hold"}, {bus.hi, bus.lo}, exp);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        ru;
        logic [63:0] exp1;
        int          n;
        int          dones;

        checks           = 0;
        errors           = 0;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.is_unsigned  = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        tick();
        tick();
        chk("reset.state", {62'd0, bus.busy, bus.done}, 64'd0);
        chk("reset.hilo", {bus.hi, bus.lo}, 64'd0);
        reset = 1'b0;
        tick();

        run_op("multu_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        chk("multu_ff.const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_min_min", 32'h8000_0000, 32'h8000_0000, 1'b0);
        chk("mult_min_min.const", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
        run_op("mult_min_one", 32'h8000_0000, 32'h0000_0001, 1'b0);
        chk("mult_min_one.const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_8000_0000);
        run_op("mult_m7_3", 32'hFFFF_FFF9, 32'd3, 1'b0);
        chk("mult_m7_3.const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("multu_m7_3", 32'hFFFF_FFF9, 32'd3, 1'b1);
        chk("multu_m7_3.const", {bus.hi, bus.lo}, 64'h0000_0002_FFFF_FFEB);
        run_op("mult_zero", 32'd0, 32'h1234_5678, 1'b0);
        run_op("multu_zero", 32'd0, 32'h1234_5678, 1'b1);

        // Starts during RUN and in the DONE cycle must be ignored.
        exp1             = ref_mul(32'h0000_1234, 32'hFFFF_0001, 1'b0);
        bus.start        = 1'b1;
        bus.multiplicand = 32'h0000_1234;
        bus.multiplier   = 32'hFFFF_0001;
        bus.is_unsigned  = 1'b0;
        tick();
        bus.start = 1'b0;
        n         = 0;
        repeat (5) begin
            tick();
            n++;
        end
        bus.start        = 1'b1;
        bus.multiplicand = 32'h7777_7777;
        bus.multiplier   = 32'h5555_5555;
        bus.is_unsigned  = 1'b1;
        tick();
        n++;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("ign.latency", 64'(n), 64'd32);
        chk("ign.hilo", {bus.hi, bus.lo}, exp1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("ign.done_start_busy", 64'(bus.busy), 64'd0);
        chk("ign.hold", {bus.hi, bus.lo}, exp1);
        tick();
        chk("ign.not_accepted", 64'(bus.busy), 64'd0);
        run_op("after_ign", 32'h7777_7777, 32'h5555_5555, 1'b1);

        // Reset at iteration 10 aborts the operation with no done.
        bus.start        = 1'b1;
        bus.multiplicand = 32'hDEAD_BEEF;
        bus.multiplier   = 32'h0BAD_F00D;
        bus.is_unsigned  = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid.state", {62'd0, bus.busy, bus.done}, 64'd0);
        chk("rst_mid.hilo", {bus.hi, bus.lo}, 64'd0);
        dones = 0;
        repeat (40) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        chk("rst_mid.no_done", 64'(dones), 64'd0);
        run_op("after_rst", 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);

        // Reset and start together: reset wins.
        reset            = 1'b1;
        bus.start        = 1'b1;
        bus.multiplicand = 32'd5;
        bus.multiplier   = 32'd6;
        tick();
        reset     = 1'b0;
        bus.start = 1'b0;
        chk("rst_start.idle", 64'(bus.busy), 64'd0);
        tick();
        chk("rst_start.still_idle", {62'd0, bus.busy, bus.done}, 64'd0);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            ru = 1'($urandom);
            if (i % 5 == 0) ra[31] = 1'b1;
            if (i % 7 == 0) rb = rb & 32'h0000_00FF;
            run_op($sformatf("rand%0d", i), ra, rb, ru);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
